// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one single-port message BRAM between the
// check-node unit (port A) and the variable-node unit (port B). It also runs
// a zero-fill sweep of the whole memory on request. The BRAM command outputs
// are registered. Read data is passed straight through from the BRAM and is
// qualified by a two-stage rvalid pipeline.
module bram_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  typedef enum logic {IDLE, INIT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              last_b;     // 1 when port B received the most recent grant
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_end;  // final sweep write issued; one drain cycle left
  logic [1:0]        rd_s1;      // {b, a} read tags, command cycle
  logic [1:0]        rd_s2;      // {b, a} read tags, data-return cycle

  assign a_rvalid = rd_s2[0];
  assign b_rvalid = rd_s2[1];
  assign a_rdata  = bram_dout;
  assign b_rdata  = bram_dout;

  // Grant logic. A single requester always wins. On a tie, the port that was
  // not granted last wins.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && state == IDLE && !init_start) begin
      if (a_req && (!b_req || last_b)) a_gnt = 1'b1;
      else if (b_req)                  b_gnt = 1'b1;
    end
  end

  // Control FSM, registered BRAM command, and read-tag pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: nonblocking assignments keep every register updating from pre-edge values.
      state     <= IDLE;
      last_b    <= 1'b1;
      sweep_cnt <= '0;
      sweep_end <= 1'b0;
      rd_s1     <= '0;
      rd_s2     <= '0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      init_done <= 1'b0;
      rd_s1     <= {b_gnt & ~b_we, a_gnt & ~a_we};
      rd_s2     <= rd_s1;
      case (state)
        IDLE: begin
          if (init_start) begin
            state     <= INIT;
            init_busy <= 1'b1;
            sweep_cnt <= '0;
            sweep_end <= 1'b0;
          end else if (a_gnt) begin
            last_b    <= 1'b0;
            bram_en   <= 1'b1;
            bram_we   <= a_we;
            bram_addr <= a_addr;
            bram_din  <= a_wdata;
          end else if (b_gnt) begin
            last_b    <= 1'b1;
            bram_en   <= 1'b1;
            bram_we   <= b_we;
            bram_addr <= b_addr;
            bram_din  <= b_wdata;
          end
        end
        INIT: begin
          if (sweep_end) begin
            state     <= IDLE;
            init_busy <= 1'b0;
            init_done <= 1'b1;
            sweep_end <= 1'b0;
          end else begin
            bram_en   <= 1'b1;
            bram_we   <= 1'b1;
            bram_din  <= '0;
            bram_addr <= sweep_cnt;
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_ADDR) sweep_end <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter. A behavioural BRAM sits on the command port.
// A cycle-indexed reference model predicts grants, BRAM commands, rvalid and
// rdata, and the init handshake. The stimulus is a directed scenario list
// followed by a random phase.
module tb_bram_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 20;
  localparam int DEPTH  = 4096;

  logic              clk;
  logic              rst_n;
  logic              init_start;
  logic              init_busy;
  logic              init_done;
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port BRAM with a 1-cycle synchronous read, write-first.
  bit [DATA_W-1:0] bmem [DEPTH];
  initial bram_dout = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bmem[bram_addr] <= bram_din;
        bram_dout       <= bram_din;
      end else begin
        bram_dout <= bmem[bram_addr];
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model state. The expected registered outputs are keyed by
  // absolute cycle number.
  bit [DATA_W-1:0] m_mem [DEPTH];
  int  cyc       = 0;
  int  busy_left = 0;   // remaining cycles with init_busy high
  int  done_cyc  = -1;  // cycle in which init_done is expected
  bit  m_last_b  = 1'b1;
  bit  m_ga, m_gb;
  bit  prev_rst  = 1'b0;
  bit  exp_arv [int];
  bit  exp_brv [int];
  bit  [DATA_W-1:0] exp_rd   [int];
  bit  exp_en  [int];
  bit  exp_we  [int];
  bit  [ADDR_W-1:0] exp_addr [int];
  bit  [DATA_W-1:0] exp_din  [int];
  int  obs_busy_cnt = 0;
  int  obs_done_cnt = 0;

  task automatic expect_cmd(input bit we, input bit [ADDR_W-1:0] ad, input bit [DATA_W-1:0] d);
    exp_en[cyc+1]   = 1'b1;
    exp_we[cyc+1]   = we;
    exp_addr[cyc+1] = ad;
    exp_din[cyc+1]  = d;
  endtask

  // Advances one clock cycle. It checks this cycle's outputs against the
  // model and then advances the model. Inputs must already be driven.
  task automatic step();
    bit e_en, e_arv, e_brv, e_busy, e_done;
    bit a_wins;
    #1;
    e_busy = (busy_left > 0);
    e_done = (cyc == done_cyc);
    e_en   = exp_en.exists(cyc);
    e_arv  = exp_arv.exists(cyc);
    e_brv  = exp_brv.exists(cyc);
    m_ga   = 1'b0;
    m_gb   = 1'b0;

    if (rst_n && busy_left == 0 && !init_start && (a_req || b_req)) begin
      // When both ports request, A wins only if B was the last one granted.
      a_wins = a_req && (!b_req || m_last_b);
      m_ga   = a_wins;
      m_gb   = !a_wins;
    end

    check("a_gnt", a_gnt, m_ga);
    check("b_gnt", b_gnt, m_gb);
    check("init_busy", init_busy, e_busy);
    check("init_done", init_done, e_done);
    check("bram_en", bram_en, e_en);
    check("bram_we", bram_we, e_en ? exp_we[cyc] : 1'b0);
    if (e_en) begin
      check("bram_addr", bram_addr, exp_addr[cyc]);
      check("bram_din", bram_din, exp_din[cyc]);
    end
    if (prev_rst) begin
      check("rst_bram_addr", bram_addr, 0);
      check("rst_bram_din", bram_din, 0);
    end
    check("a_rvalid", a_rvalid, e_arv);
    check("b_rvalid", b_rvalid, e_brv);
    if (e_arv) check("a_rdata", a_rdata, exp_rd[cyc]);
    if (e_brv) check("b_rdata", b_rdata, exp_rd[cyc]);
    if (init_busy) obs_busy_cnt++;
    if (init_done) obs_done_cnt++;

    if (!rst_n) begin
      busy_left = 0;
      done_cyc  = -1;
      m_last_b  = 1'b1;
      exp_arv.delete(cyc+1);
      exp_brv.delete(cyc+1);
      exp_en.delete(cyc+1);
    end else if (busy_left > 0) begin
      if (busy_left > 1) expect_cmd(1'b1, ADDR_W'(DEPTH + 1 - busy_left), '0);
      busy_left--;
      if (busy_left == 0) done_cyc = cyc + 1;
    end else if (init_start) begin
      busy_left = DEPTH + 1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_ga || m_gb) begin
      m_last_b = m_gb;
      if (m_ga) begin
        expect_cmd(a_we, a_addr, a_wdata);
        if (a_we) m_mem[a_addr] = a_wdata;
        else begin exp_arv[cyc+2] = 1'b1; exp_rd[cyc+2] = m_mem[a_addr]; end
      end else begin
        expect_cmd(b_we, b_addr, b_wdata);
        if (b_we) m_mem[b_addr] = b_wdata;
        else begin exp_brv[cyc+2] = 1'b1; exp_rd[cyc+2] = m_mem[b_addr]; end
      end
    end
    prev_rst = !rst_n;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds a request on port A until the model grants it (bounded wait).
  task automatic access_a(input bit we, input bit [ADDR_W-1:0] ad, input bit [DATA_W-1:0] d);
    bit got = 1'b0;
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = d;
    for (int i = 0; i < 6000 && !got; i++) begin
      step();
      got = m_ga;
    end
    a_req = 1'b0;
    check("a_grant_within_bound", got, 1);
  endtask

  task automatic access_b(input bit we, input bit [ADDR_W-1:0] ad, input bit [DATA_W-1:0] d);
    bit got = 1'b0;
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = d;
    for (int i = 0; i < 6000 && !got; i++) begin
      step();
      got = m_gb;
    end
    b_req = 1'b0;
    check("b_grant_within_bound", got, 1);
  endtask

  initial begin
    bit got_b, done_with_gnt;
    rst_n = 1'b0; init_start = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; requests are ignored while reset is held.
    a_req = 1'b1; b_req = 1'b1;
    idle(2);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // Single port: write 22 = 3456, then read it back.
    access_a(1'b1, 12'd22, 20'd3456);
    access_a(1'b0, 12'd22, '0);
    idle(3);

    // Preload distinct addresses for the contention run.
    for (int i = 0; i < 4; i++) access_a(1'b1, ADDR_W'(100 + i), DATA_W'(1000 + i));
    for (int i = 0; i < 4; i++) access_b(1'b1, ADDR_W'(200 + i), DATA_W'(2000 + i));

    // Contention: both ports hold read requests for 6 cycles.
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd200;
    for (int i = 0; i < 6; i++) begin
      step();
      check("contention_a_turn", m_ga, (i % 2 == 0));
      if (m_ga) a_addr = a_addr + 1'b1;
      if (m_gb) b_addr = b_addr + 1'b1;
    end
    a_req = 1'b0; b_req = 1'b0;
    idle(3);

    // Init sweep: preload, sweep, and request during the sweep.
    access_a(1'b1, 12'd22, 20'd3456);
    access_b(1'b1, 12'd4095, 20'd1);
    obs_busy_cnt = 0;
    obs_done_cnt = 0;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    idle(1000);
    init_start = 1'b1;                 // ignored: sweep already running
    step();
    init_start = 1'b0;
    idle(1000);
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd5;
    got_b = 1'b0;
    done_with_gnt = 1'b0;
    for (int i = 0; i < 6000 && !got_b; i++) begin
      step();
      got_b = m_gb;
      if (got_b) done_with_gnt = (obs_done_cnt == 1);
    end
    b_req = 1'b0;
    check("b_granted_after_sweep", got_b, 1);
    check("b_grant_in_done_cycle", done_with_gnt, 1);
    check("init_busy_cycles", obs_busy_cnt, DEPTH + 1);
    idle(3);
    check("init_done_pulses", obs_done_cnt, 1);
    access_a(1'b0, 12'd22, '0);
    access_a(1'b0, 12'd4095, '0);
    idle(3);

    // Reset mid-read, then the first tie goes to A.
    access_a(1'b1, 12'd9, 20'd777);
    access_b(1'b1, 12'd8, 20'd555);      // last grant = B
    access_a(1'b0, 12'd9, '0);           // last grant = A
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(3);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd9;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd8;
    step();
    check("tie_after_reset_a", m_ga, 1);
    a_req = 1'b0;
    step();
    b_req = 1'b0;
    idle(3);

    // Randomized traffic on a small address window.
    for (int i = 0; i < 500; i++) begin
      if (!a_req && $urandom_range(1, 0) == 1) begin
        a_req = 1'b1; a_we = 1'($urandom_range(1, 0));
        a_addr = ADDR_W'($urandom_range(15, 0)); a_wdata = DATA_W'($urandom);
      end
      if (!b_req && $urandom_range(1, 0) == 1) begin
        b_req = 1'b1; b_we = 1'($urandom_range(1, 0));
        b_addr = ADDR_W'($urandom_range(15, 0)); b_wdata = DATA_W'($urandom);
      end
      step();
      if (m_ga) a_req = 1'b0;
      if (m_gb) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
